matmul_result_drain: RTL
========================

# matmul_result_drain

Reads the MATMUL result array after each multiply and streams the valid m x p region out one element per beat, in row-major order, over a valid/ready interface. It connects the parallel dataOut/done side of the accelerator to the serial writeback path, such as a result FIFO or a memory writer. While draining, it asserts busy so the accelerator controller does not restart MATMUL and overwrite dataOut.

## Interface
- BITS, 8, bit width of each input pixel; result elements are 2*BITS wide
- DIM, 32, maximum matrix dimension; dataOut is DIM x DIM
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- done  in  1  MATMUL completion flag; a rising edge starts a drain
- m  in  $clog2(DIM)+1  number of result rows
- p  in  $clog2(DIM)+1  number of result columns
- dataOut  in  [BITS*2-1:0] [DIM-1:0][DIM-1:0]  MATMUL result array; stable until MATMUL is re-enabled
- out_ready  in  1  downstream can accept a beat
- out_valid  out  1  out_data holds a valid element
- out_data  out  BITS*2  result element dataOut[out_row][out_col]
- out_row  out  $clog2(DIM)  row index of the current beat
- out_col  out  $clog2(DIM)  column index of the current beat
- out_last  out  1  current beat is element (rows-1, cols-1)
- busy  out  1  drain in progress; upstream must not re-enable MATMUL
- drain_done  out  1  one-cycle pulse after the final beat transfers, or after an empty drain
- overrun  out  1  sticky flag: a done rising edge arrived while busy

## Operation
- Two states, IDLE and STREAM.
- A done_q register detects the rising edge of done. A start event is done=1 and done_q=0, sampled in IDLE.
- On a start event:
  - Latch rows = min(m, DIM) and cols = min(p, DIM). Any m or p value above DIM is clamped to DIM.
  - If rows = 0 or cols = 0: pulse drain_done on the next cycle, emit no beats, stay in IDLE. busy stays 0.
  - Otherwise: load out_data = dataOut[0][0], set out_row = out_col = 0, out_valid = 1, busy = 1, and go to STREAM.
- In STREAM, a transfer occurs at any edge where out_valid = 1 and out_ready = 1. On a transfer:
  - If the beat was not last, advance the column. When col = cols-1, wrap col to 0 and increment row.
  - Load out_data from dataOut at the new (row, col).
  - out_last = 1 exactly when the next (row, col) = (rows-1, cols-1).
  - If the beat was last: out_valid = 0, out_last = 0, busy = 0, drain_done = 1 for one cycle, go to IDLE.
- When out_valid = 1 and out_ready = 0, the outputs (data, row, col, last) hold stable. There is no bubble and no data change.
- A done rising edge while busy does not start a new drain. It sets overrun = 1, which stays set until reset.
- out_data is a direct copy of the 2*BITS-wide element: no truncation and no sign handling (unsigned).

## Timing
- Reset values: out_valid = 0, out_data = 0, out_row = 0, out_col = 0, out_last = 0, busy = 0, drain_done = 0, overrun = 0, state = IDLE, done_q = 1.
- Because done_q resets to 1, a done held high through reset does not start a drain. A fresh 0 to 1 transition is required.
- Start latency: out_valid is high in the cycle after the edge where the start event was sampled.
- Throughput: one beat per cycle while out_ready = 1. A full drain takes rows*cols transfer edges.
- drain_done is high in the cycle after the last transfer edge. Earliest next start is at the edge following drain_done.
- Reset in mid-drain (rst_n = 0 at any edge) discards the remaining beats and restores all reset values at that edge.
- If the state is IDLE when rst_n is released, a simultaneous done rising edge starts a drain only if done was 0 in some sampled cycle after reset.
- 1 x 1 drain: the first beat has out_last = 1 immediately.

## Test plan
- m = p = 2, dataOut[i][j] = 10*i + j, out_ready = 1: beats 0, 1, 10, 11 on four consecutive cycles. out_last is high on 11 only, and drain_done pulses one cycle later.
- m = 5, p = 3, random dataOut, out_ready toggled randomly: exactly 15 beats in row-major order, each matching dataOut[row][col]. Data is held stable during every stall.
- m = 0 or p = 0: no out_valid, drain_done pulses once, and busy stays 0.
- m = p = 33 (above DIM = 32): the dimension is clamped and exactly 1024 beats are produced. The last beat is (31, 31) with out_last = 1.
- A second done edge mid-drain sets overrun = 1 and the current drain completes unchanged. rst_n pulsed low mid-drain gives out_valid = 0 and busy = 0 at the next edge, with overrun cleared.
- done held at 1 through reset: no drain starts. Dropping done to 0 and raising it again starts one drain.

Source files
------------

// File: rtl/matmul_result_drain.sv
// matmul_result_drain
// Drains the valid rows x cols region of the MATMUL result array as a
// row-major stream. It emits one element per beat over a valid/ready
// handshake.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   done              MATMUL completion flag; a rising edge starts a drain
//   m, p              result rows / columns; values above DIM are clamped
//   dataOut           result array, indexed [row][col]
//   out_ready         downstream accepts the current beat
//   out_valid/data    current beat and its element value
//   out_row/col       coordinates of the current beat
//   out_last          current beat is (rows-1, cols-1)
//   busy              drain in progress
//   drain_done        one-cycle pulse when a drain (possibly empty) completes
//   overrun           sticky: done rose while a drain was still in progress
module matmul_result_drain #(
    parameter int BITS = 8,
    parameter int DIM  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     done,
    input  logic [$clog2(DIM):0]     m,
    input  logic [$clog2(DIM):0]     p,
    input  logic [BITS*2-1:0]        dataOut [DIM-1:0][DIM-1:0],
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [BITS*2-1:0]        out_data,
    output logic [$clog2(DIM)-1:0]   out_row,
    output logic [$clog2(DIM)-1:0]   out_col,
    output logic                     out_last,
    output logic                     busy,
    output logic                     drain_done,
    output logic                     overrun
);
    localparam int IW = $clog2(DIM);
    localparam int CW = IW + 1;
    localparam int DW = BITS * 2;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic [CW-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [IW-1:0] row_q, row_d, col_q, col_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d, last_q, last_d;
    logic          busy_q, busy_d, ddone_q, ddone_d, ovr_q, ovr_d;

    logic          start;
    logic [CW-1:0] rows_n, cols_n;
    logic [IW-1:0] nrow, ncol;

    function automatic logic [CW-1:0] clamp_dim(input logic [CW-1:0] v);
        return (v > CW'(DIM)) ? CW'(DIM) : v;
    endfunction

    assign start  = done && !done_q;
    assign rows_n = clamp_dim(m);
    assign cols_n = clamp_dim(p);

    // Row-major successor of the current beat.
    always_comb begin
        ncol = col_q + 1'b1;
        nrow = row_q;
        if ({1'b0, col_q} == cols_q - 1'b1) begin
            ncol = '0;
            nrow = row_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done;
        rows_d  = rows_q;
        cols_d  = cols_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        ddone_d = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d = rows_n;
                    cols_d = cols_n;
                    if (rows_n == '0 || cols_n == '0) begin
                        // Empty region: report completion without streaming.
                        ddone_d = 1'b1;
                    end else begin
                        row_d   = '0;
                        col_d   = '0;
                        data_d  = dataOut[0][0];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        last_d  = (rows_n == CW'(1)) && (cols_n == CW'(1));
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                // A restart here would clobber dataOut mid-drain; flag it only.
                if (start) ovr_d = 1'b1;
                if (out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        ddone_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d  = nrow;
                        col_d  = ncol;
                        data_d = dataOut[nrow][ncol];
                        last_d = ({1'b0, nrow} == rows_q - 1'b1) &&
                                 ({1'b0, ncol} == cols_q - 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            // Reset high so a done held through reset is not seen as an edge.
            done_q  <= 1'b1;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ddone_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ddone_q <= ddone_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = last_q;
    assign busy       = busy_q;
    assign drain_done = ddone_q;
    assign overrun    = ovr_q;
endmodule
